// File: rtl/mem_types.sv
// Shared types for the memory stage: RV32I word and funct3 encodings, plus
// the stage FSM state and the alignment-check helper.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

endpackage

package mem_types;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  // Access size comes from funct3[1:0] for both loads and stores:
  // 2'b10 = word, 2'b01 = half, anything else = byte (never misaligned).
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      2'b10:   mis = (addr_lo != 2'b00);
      2'b01:   mis = addr_lo[0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data-memory port: store byte-enables and shifted
// write data, and load byte/half extraction with sign or zero extension.
module mem_align
  import rv32i_types::*;
(
  input  store_funct3_t st_funct3_i,
  input  logic [1:0]    st_addr_lo_i,
  input  rv32i_word     st_data_i,
  output logic [3:0]    st_mbe_o,
  output rv32i_word     st_wdata_o,
  input  load_funct3_t  ld_funct3_i,
  input  logic [1:0]    ld_addr_lo_i,
  input  rv32i_word     ld_rdata_i,
  output rv32i_word     ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store mask follows the access size; data is always shifted into the lane.
  always_comb begin
    st_wdata_o = st_data_i << {st_addr_lo_i, 3'b000};
    case (st_funct3_i)
      sb:      st_mbe_o = 4'b0001 << st_addr_lo_i;
      sh:      st_mbe_o = 4'b0011 << st_addr_lo_i;
      default: st_mbe_o = 4'b1111;
    endcase
  end

  // Pick the addressed byte/half, then extend according to the load type.
  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
    case (ld_funct3_i)
      lb:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      lbu:     ld_data_o = {24'h000000, ld_byte};
      lh:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      lhu:     ld_data_o = {16'h0000, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store, stalls
// upstream until dmem_resp, and registers the MEM/WB outputs.
module mem_stage
  import rv32i_types::*;
  import mem_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exmem_valid,
  input  logic        exmem_load,
  input  logic        exmem_store,
  input  logic [2:0]  exmem_funct3,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rs2_out,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        mem_stall,
  output logic        memwb_valid,
  output logic [31:0] memwb_alu_out,
  output logic [31:0] memwb_rdata,
  output logic [4:0]  memwb_rd,
  output logic        memwb_regwrite,
  output logic        memwb_misalign
);

  mem_state_e state_q, state_d;

  // Latched request; dmem_read_q/dmem_write_q double as the load/store flags.
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  rv32i_word   addr_q, addr_d;
  rv32i_word   wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;

  logic        wb_valid_q, wb_valid_d;
  rv32i_word   wb_alu_q, wb_alu_d;
  rv32i_word   wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_misalign_q, wb_misalign_d;

  logic        is_mem_op;
  logic        misalign;
  logic        mem_req;
  logic [3:0]  st_mbe;
  rv32i_word   st_wdata;
  rv32i_word   ld_data;

  assign is_mem_op = exmem_load | exmem_store;
  assign misalign  = is_mem_op & is_misaligned(exmem_funct3[1:0], exmem_alu_out[1:0]);
  assign mem_req   = exmem_valid & is_mem_op & ~misalign;

  // Stores are steered from the incoming instruction; loads are extracted
  // using the latched funct3/address since the response arrives later.
  mem_align u_align (
    .st_funct3_i  (store_funct3_t'(exmem_funct3)),
    .st_addr_lo_i (exmem_alu_out[1:0]),
    .st_data_i    (exmem_rs2_out),
    .st_mbe_o     (st_mbe),
    .st_wdata_o   (st_wdata),
    .ld_funct3_i  (load_funct3_t'(funct3_q)),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_rdata_i   (dmem_rdata),
    .ld_data_o    (ld_data)
  );

  // State and all registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      dmem_read_q   <= 1'b0;
      dmem_write_q  <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mbe_q         <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
      regwrite_q    <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_alu_q      <= '0;
      wb_rdata_q    <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dmem_read_q   <= dmem_read_d;
      dmem_write_q  <= dmem_write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mbe_q         <= mbe_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      regwrite_q    <= regwrite_d;
      wb_valid_q    <= wb_valid_d;
      wb_alu_q      <= wb_alu_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_misalign_q <= wb_misalign_d;
    end
  end

  // Next-state, request latching, MEM/WB capture and stall generation.
  // Default MEM/WB action is a bubble; request registers hold.
  always_comb begin
    state_d       = state_q;
    dmem_read_d   = dmem_read_q;
    dmem_write_d  = dmem_write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mbe_d         = mbe_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    regwrite_d    = regwrite_q;
    wb_valid_d    = 1'b0;
    wb_alu_d      = wb_alu_q;
    wb_rdata_d    = wb_rdata_q;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = 1'b0;
    wb_misalign_d = 1'b0;
    mem_stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          dmem_read_d  = exmem_load;
          dmem_write_d = exmem_store;
          addr_d       = exmem_alu_out;
          wdata_d      = exmem_store ? st_wdata : '0;
          mbe_d        = exmem_store ? st_mbe : 4'b0000;
          funct3_d     = exmem_funct3;
          rd_d         = exmem_rd;
          regwrite_d   = exmem_regwrite;
          state_d      = ACCESS;
          mem_stall    = 1'b1;
        end else if (exmem_valid) begin
          // Non-memory op or misaligned access: one-cycle pass-through.
          wb_valid_d    = 1'b1;
          wb_alu_d      = exmem_alu_out;
          wb_rdata_d    = '0;
          wb_rd_d       = exmem_rd;
          wb_regwrite_d = exmem_regwrite & ~misalign;
          wb_misalign_d = misalign;
        end
      end
      ACCESS: begin
        if (dmem_resp) begin
          wb_valid_d    = 1'b1;
          wb_alu_d      = addr_q;
          wb_rdata_d    = dmem_read_q ? ld_data : '0;
          wb_rd_d       = rd_q;
          wb_regwrite_d = regwrite_q;
          dmem_read_d   = 1'b0;
          dmem_write_d  = 1'b0;
          mbe_d         = 4'b0000;
          state_d       = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dmem_read      = dmem_read_q;
  assign dmem_write     = dmem_write_q;
  assign dmem_address   = {addr_q[31:2], 2'b00};
  assign dmem_wdata     = wdata_q;
  assign dmem_mbe       = mbe_q;
  assign memwb_valid    = wb_valid_q;
  assign memwb_alu_out  = wb_alu_q;
  assign memwb_rdata    = wb_rdata_q;
  assign memwb_rd       = wb_rd_q;
  assign memwb_regwrite = wb_regwrite_q;
  assign memwb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, delayed store,
// misaligned access and reset in the middle of an access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_valid, exmem_load, exmem_store, exmem_regwrite;
  logic [2:0]  exmem_funct3;
  logic [31:0] exmem_alu_out, exmem_rs2_out;
  logic [4:0]  exmem_rd;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_mbe;
  logic        mem_stall, memwb_valid, memwb_regwrite, memwb_misalign;
  logic [31:0] memwb_alu_out, memwb_rdata;
  logic [4:0]  memwb_rd;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .exmem_valid    (exmem_valid),
    .exmem_load     (exmem_load),
    .exmem_store    (exmem_store),
    .exmem_funct3   (exmem_funct3),
    .exmem_alu_out  (exmem_alu_out),
    .exmem_rs2_out  (exmem_rs2_out),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_address   (dmem_address),
    .dmem_wdata     (dmem_wdata),
    .dmem_mbe       (dmem_mbe),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .mem_stall      (mem_stall),
    .memwb_valid    (memwb_valid),
    .memwb_alu_out  (memwb_alu_out),
    .memwb_rdata    (memwb_rdata),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_misalign (memwb_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw);
    exmem_valid    = v;
    exmem_load     = ld;
    exmem_store    = st;
    exmem_funct3   = f3;
    exmem_alu_out  = alu;
    exmem_rs2_out  = rs2;
    exmem_rd       = rd;
    exmem_regwrite = rw;
  endtask

  initial begin
    rst = 1'b1;
    dmem_resp = 1'b0;
    dmem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    chk("rst_dmem_read", {31'b0, dmem_read}, 32'd0);
    chk("rst_dmem_write", {31'b0, dmem_write}, 32'd0);
    chk("rst_memwb_valid", {31'b0, memwb_valid}, 32'd0);
    chk("rst_dmem_mbe", {28'b0, dmem_mbe}, 32'd0);
    chk("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
    rst = 1'b0;

    // add pass-through
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    #1;
    chk("add_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    $display("txn add: valid=%0b alu=%h rd=%0d", memwb_valid, memwb_alu_out, memwb_rd);
    chk("add_valid", {31'b0, memwb_valid}, 32'd1);
    chk("add_alu", memwb_alu_out, 32'h1234);
    chk("add_rd", {27'b0, memwb_rd}, 32'd5);
    chk("add_regwrite", {31'b0, memwb_regwrite}, 32'd1);
    chk("add_no_read", {31'b0, dmem_read}, 32'd0);
    chk("add_no_write", {31'b0, dmem_write}, 32'd0);

    // lb 0x103, response in the first ACCESS cycle
    drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1);
    #1;
    chk("lb_accept_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    chk("lb_read", {31'b0, dmem_read}, 32'd1);
    chk("lb_addr", dmem_address, 32'h100);
    chk("lb_mbe", {28'b0, dmem_mbe}, 32'd0);
    chk("lb_bubble", {31'b0, memwb_valid}, 32'd0);
    dmem_resp = 1'b1;
    dmem_rdata = 32'h80FF7F01;
    #1;
    chk("lb_resp_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    $display("txn lb: valid=%0b rdata=%h", memwb_valid, memwb_rdata);
    chk("lb_valid", {31'b0, memwb_valid}, 32'd1);
    chk("lb_rdata", memwb_rdata, 32'hFFFFFF80);
    chk("lb_rd", {27'b0, memwb_rd}, 32'd6);
    chk("lb_alu", memwb_alu_out, 32'h103);
    chk("lb_read_drop", {31'b0, dmem_read}, 32'd0);

    // lbu on the same data
    dmem_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 1'b1);
    tick();
    dmem_resp = 1'b1;
    tick();
    $display("txn lbu: valid=%0b rdata=%h", memwb_valid, memwb_rdata);
    chk("lbu_rdata", memwb_rdata, 32'h00000080);

    // lh 0x102 -> upper half 0x80FF, sign-extended
    dmem_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 1'b1);
    tick();
    dmem_resp = 1'b1;
    tick();
    $display("txn lh: valid=%0b rdata=%h", memwb_valid, memwb_rdata);
    chk("lh_rdata", memwb_rdata, 32'hFFFF80FF);

    // sh 0x202, response delayed three ACCESS cycles
    dmem_resp = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 5'd0, 1'b0);
    #1;
    chk("sh_stall_0", {31'b0, mem_stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sh_stall_wait", {31'b0, mem_stall}, 32'd1);
      chk("sh_write_held", {31'b0, dmem_write}, 32'd1);
      chk("sh_mbe", {28'b0, dmem_mbe}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hBEEF0000);
      chk("sh_addr", dmem_address, 32'h200);
    end
    tick();
    dmem_resp = 1'b1;
    #1;
    chk("sh_resp_stall", {31'b0, mem_stall}, 32'd0);
    chk("sh_write_last", {31'b0, dmem_write}, 32'd1);
    tick();
    $display("txn sh: valid=%0b write=%0b", memwb_valid, dmem_write);
    chk("sh_write_drop", {31'b0, dmem_write}, 32'd0);
    chk("sh_valid", {31'b0, memwb_valid}, 32'd1);
    chk("sh_rdata", memwb_rdata, 32'h0);

    // sb 0x107 -> lane 3
    dmem_resp = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h107, 32'h000000AB, 5'd0, 1'b0);
    tick();
    $display("txn sb: mbe=%b wdata=%h", dmem_mbe, dmem_wdata);
    chk("sb_mbe", {28'b0, dmem_mbe}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hAB000000);
    dmem_resp = 1'b1;
    tick();

    // lw 0x301: misaligned, single cycle, no memory access
    dmem_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 5'd7, 1'b1);
    #1;
    chk("mis_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    $display("txn lw-mis: valid=%0b misalign=%0b regwrite=%0b", memwb_valid, memwb_misalign, memwb_regwrite);
    chk("mis_no_read", {31'b0, dmem_read}, 32'd0);
    chk("mis_flag", {31'b0, memwb_misalign}, 32'd1);
    chk("mis_regwrite", {31'b0, memwb_regwrite}, 32'd0);
    chk("mis_valid", {31'b0, memwb_valid}, 32'd1);

    // reset during an outstanding lw, then a late response
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1);
    tick();
    chk("rr_read", {31'b0, dmem_read}, 32'd1);
    #2;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    chk("rr_read_async", {31'b0, dmem_read}, 32'd0);
    chk("rr_valid_async", {31'b0, memwb_valid}, 32'd0);
    tick();
    rst = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h12345678;
    tick();
    $display("txn rst-late-resp: valid=%0b read=%0b", memwb_valid, dmem_read);
    chk("rr_late_valid", {31'b0, memwb_valid}, 32'd0);
    chk("rr_late_read", {31'b0, dmem_read}, 32'd0);

    // next load proceeds normally
    dmem_resp = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd9, 1'b1);
    #1;
    chk("post_stall", {31'b0, mem_stall}, 32'd1);
    tick();
    chk("post_read", {31'b0, dmem_read}, 32'd1);
    chk("post_addr", dmem_address, 32'h500);
    dmem_resp = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick();
    $display("txn lw: valid=%0b rdata=%h rd=%0d", memwb_valid, memwb_rdata, memwb_rd);
    chk("post_valid", {31'b0, memwb_valid}, 32'd1);
    chk("post_rdata", memwb_rdata, 32'hCAFEF00D);
    chk("post_rd", {27'b0, memwb_rd}, 32'd9);
    chk("post_regwrite", {31'b0, memwb_regwrite}, 32'd1);
    dmem_resp = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    tick();
    chk("idle_bubble", {31'b0, memwb_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register contents: the ALU result used as the address, the rs2 value used as store data, and the control bits.
- Drives the data-memory port with a request/response handshake and stalls the pipeline while an access is outstanding.
- Produces the registered MEM/WB outputs, including aligned, sign- or zero-extended load data.

Parameters:
- None. Widths are fixed by rv32i_word (32 bits) and the 5-bit register index.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
exmem_valid  in  1  EX/MEM holds a real instruction
exmem_load  in  1  instruction is a load
exmem_store  in  1  instruction is a store
exmem_funct3  in  3  load_funct3_t/store_funct3_t encoding
exmem_alu_out  in  32  ALU result; effective address for loads/stores
exmem_rs2_out  in  32  store data
exmem_rd  in  5  destination register
exmem_regwrite  in  1  instruction writes rd
dmem_read  out  1  data read request (registered)
dmem_write  out  1  data write request (registered)
dmem_address  out  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata  out  32  lane-shifted store data
dmem_mbe  out  4  byte-enable mask
dmem_rdata  in  32  read data, valid with dmem_resp
dmem_resp  in  1  access complete
mem_stall  out  1  upstream must hold EX/MEM and earlier stages
memwb_valid  out  1  MEM/WB holds a real instruction
memwb_alu_out  out  32  passed-through ALU result
memwb_rdata  out  32  aligned/extended load data
memwb_rd  out  5  destination register
memwb_regwrite  out  1  write-enable for writeback (0 on misalign)
memwb_misalign  out  1  misaligned access detected; no memory access made

Behaviour:
- Reset (async, rst=1): state=IDLE. All dmem_* outputs, memwb_* outputs and the latched request registers are 0. An in-flight access is abandoned. A dmem_resp arriving after reset is ignored.
- FSM has two states, IDLE and ACCESS.
- mem_req = exmem_valid & (exmem_load|exmem_store) & ~misalign.
- misalign conditions: lw/sw with addr[1:0]!=0; lh/lhu/sh with addr[0]=1. Byte accesses are never misaligned.
- IDLE, mem_req=1:
  - Latch address, mbe, wdata, funct3, rd, regwrite and load/store.
  - Next state ACCESS. memwb_valid<=0 (bubble).
  - mem_stall=1 combinationally this cycle.
- IDLE, non-memory valid instruction or misaligned access:
  - Single cycle. MEM/WB loads pass-through values on the next edge. mem_stall=0.
  - On misalign: memwb_misalign=1, memwb_regwrite=0, dmem untouched.
- IDLE, exmem_valid=0: memwb_valid<=0.
- ACCESS:
  - dmem_read/dmem_write held from the latched request until the edge ending the dmem_resp cycle.
  - dmem_resp=0: mem_stall=1, memwb_valid<=0, remain in ACCESS.
  - dmem_resp=1: mem_stall=0. MEM/WB captures the extracted rdata (loads) or 0 (stores). memwb_valid<=1. Next state IDLE. dmem_read/write<=0.
- Minimum load latency is 2 cycles from acceptance to memwb_valid; dmem_resp may arrive in the first ACCESS cycle.
- Stores:
  - sb: mbe=4'b0001<<addr[1:0]
  - sh: mbe=4'b0011<<addr[1:0]
  - sw: mbe=4'b1111
  - wdata=rs2<<(8*addr[1:0]) in all cases.
- Loads:
  - lb/lbu select byte addr[1:0]; lh/lhu select half addr[1].
  - Sign-extend for lb/lh, zero-extend for lbu/lhu; lw is unmodified.
- dmem_address, dmem_mbe and dmem_wdata are stable for the whole ACCESS period. dmem_mbe=0 for reads.
- dmem_resp seen in IDLE is ignored.

Decomposition:
- Shared package mem_types holds the FSM state enum (IDLE, ACCESS) and the misalign-check helper. Reuse load_funct3_t/store_funct3_t from rv32i_types.
- One combinational sub-module, mem_align, generates mbe and wdata from funct3/addr and performs load extraction/extension.

Test Plan:
- add passthrough, alu_out=0x1234, rd=5, regwrite=1 -> next cycle memwb_valid=1, memwb_alu_out=0x1234, mem_stall=0, no dmem activity.
- lb addr 0x103, dmem_rdata=0x80FF7F01, resp in first ACCESS cycle -> dmem_address=0x100, memwb_rdata=0xFFFFFF80, memwb_valid 2 cycles after accept. lbu on the same data -> 0x00000080.
- sh addr 0x202, rs2=0x0000BEEF, resp delayed 3 cycles -> mbe=4'b1100, wdata=0xBEEF0000, mem_stall high 4 cycles, dmem_write drops after resp.
- lw addr 0x301 -> no dmem_read, memwb_misalign=1, memwb_regwrite=0, single cycle.
- rst asserted mid-ACCESS (lw outstanding), then late dmem_resp -> dmem_read=0 immediately, memwb_valid=0, resp ignored, next load proceeds normally.
